// File: rtl/shift_register_param.sv
// Purpose: WIDTH-bit universal shifter (shift/rotate/arith/load/hold) with a load-and-serialise burst mode.
// Latency: every operation updates Q/S_OUT on the next rising edge; a burst takes 1 load edge + WIDTH shift edges.
// Backpressure: ENB=0 freezes all state (including a burst in flight); START while BUSY is dropped, not queued.
module shift_register_param #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [2:0]       MODO,
    input  logic             START,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             s_out_q, s_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CW-1:0]    count_q, count_d;
    logic             dir_q, dir_d;

    // Candidate shift results shared by the IDLE ops and the burst shifter.
    logic [WIDTH-1:0] shl_log, shr_log, shl_rot, shr_rot, shl_ari, shr_ari;

    // Precompute every shift flavour from the current register contents.
    always_comb begin
        shl_log = {q_q[WIDTH-2:0], S_IN};
        shr_log = {S_IN, q_q[WIDTH-1:1]};
        shl_rot = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        shr_rot = {q_q[0], q_q[WIDTH-1:1]};
        shl_ari = {q_q[WIDTH-2:0], 1'b0};
        shr_ari = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
    end

    // Next-state logic: IDLE runs the MODO op or launches a burst; SHIFT serialises until count hits 1.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        s_out_d = s_out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        count_d = count_q;
        dir_d   = dir_q;

        if (ENB) begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        q_d     = D;
                        dir_d   = DIR;
                        count_d = CNT_FULL;
                        busy_d  = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        case (MODO)
                            3'b000: begin
                                q_d     = DIR ? shr_log : shl_log;
                                s_out_d = DIR ? q_q[0] : q_q[WIDTH-1];
                            end
                            3'b001: begin
                                q_d     = DIR ? shr_rot : shl_rot;
                                s_out_d = DIR ? q_q[0] : q_q[WIDTH-1];
                            end
                            3'b010: q_d = D;
                            3'b100: begin
                                q_d     = DIR ? shr_ari : shl_ari;
                                s_out_d = DIR ? q_q[0] : q_q[WIDTH-1];
                            end
                            default: ;  // hold, including reserved codes
                        endcase
                    end
                end
                ST_SHIFT: begin
                    q_d     = dir_q ? shr_log : shl_log;
                    s_out_d = dir_q ? q_q[0] : q_q[WIDTH-1];
                    count_d = count_q - 1'b1;
                    if (count_q == CNT_ONE) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers with synchronous reset; reset also aborts a burst without a DONE pulse.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= ST_IDLE;
            q_q     <= RST_VAL;
            s_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            s_out_q <= s_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
            dir_q   <= dir_d;
        end
    end

    assign Q     = q_q;
    assign S_OUT = s_out_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_shift_register_param.sv
// Purpose: directed table-driven bench for shift_register_param (WIDTH=8, RST_VAL=0) plus burst sequences.
// Latency: inputs driven 1 time unit after a rising edge; outputs sampled 1 time unit after the next edge.
// Backpressure: stalls are exercised by holding ENB low mid-burst.
module tb_shift_register_param;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         RST, ENB, DIR, S_IN, START;
    logic [2:0]   MODO;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic         S_OUT, BUSY, DONE;

    int errors = 0;
    int checks = 0;

    shift_register_param #(.WIDTH(W), .RST_VAL(8'h00)) dut (
        .clk   (clk),
        .RST   (RST),
        .ENB   (ENB),
        .DIR   (DIR),
        .S_IN  (S_IN),
        .MODO  (MODO),
        .START (START),
        .D     (D),
        .Q     (Q),
        .S_OUT (S_OUT),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         enb;
        logic         dir;
        logic         s_in;
        logic [2:0]   modo;
        logic         start;
        logic [W-1:0] d;
        logic [W-1:0] exp_q;
        logic         exp_sout;
        logic         exp_busy;
        logic         exp_done;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic enb, input logic dir, input logic s_in,
                         input logic [2:0] modo, input logic start, input logic [W-1:0] d);
        RST = rst; ENB = enb; DIR = dir; S_IN = s_in; MODO = modo; START = start; D = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input logic stall, input logic extra_start, input logic [W-1:0] dval);
        int busy_cnt;
        int done_cnt;
        logic [W-1:0] exp_q;
        logic prev_bit;
        busy_cnt = 0;
        done_cnt = 0;
        exp_q = dval;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 1'b1, dval);
        tick();
        chk("burst_load_q", Q, dval);
        chk("burst_load_busy", BUSY, 1);
        if (BUSY) busy_cnt++;
        prev_bit = 1'bx;
        for (int i = 0; i < W; i++) begin
            if (stall && i == 4) begin
                for (int s = 0; s < 3; s++) begin
                    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 8'hFF);
                    tick();
                    chk("stall_q", Q, exp_q);
                    chk("stall_sout", S_OUT, prev_bit);
                    chk("stall_done", DONE, 0);
                    if (BUSY) busy_cnt++;
                    if (DONE) done_cnt++;
                end
            end
            // Garbage on DIR/MODO/D must be ignored; optionally a START while busy.
            drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, (extra_start && i == 5), 8'hFF);
            tick();
            prev_bit = dval[i];
            exp_q = exp_q >> 1;
            chk("burst_sout", S_OUT, dval[i]);
            chk("burst_q", Q, exp_q);
            if (BUSY) busy_cnt++;
            if (DONE) done_cnt++;
        end
        chk("burst_busy_end", BUSY, 0);
        chk("burst_done_end", DONE, 1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 1'b0, 8'h00);
            tick();
            if (BUSY) busy_cnt++;
            if (DONE) done_cnt++;
        end
        chk("burst_busy_cycles", busy_cnt, stall ? W + 3 : W);
        chk("burst_done_count", done_cnt, 1);
        chk("no_second_burst_q", Q, 8'h00);
    endtask

    initial begin
        //            rst  enb  dir  sin  modo    start d      exp_q  sout busy done
        vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,3'b000,1'b1,8'hFF, 8'h00,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,3'b010,1'b0,8'hA5, 8'hA5,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,3'b001,1'b0,8'h00, 8'h4B,1'b1,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,3'b010,1'b0,8'hA5, 8'hA5,1'b1,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,3'b001,1'b0,8'h00, 8'hD2,1'b1,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,3'b010,1'b0,8'h90, 8'h90,1'b1,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b1,1'b1,1'b0,3'b100,1'b0,8'h00, 8'hC8,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,3'b010,1'b0,8'h90, 8'h90,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b1,1'b1,1'b0,3'b000,1'b0,8'h00, 8'h48,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,3'b000,1'b0,8'h00, 8'h91,1'b0,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b1,1'b0,1'b1,3'b100,1'b0,8'h00, 8'h22,1'b1,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b1,1'b1,1'b1,3'b011,1'b0,8'hFF, 8'h22,1'b1,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b1,1'b1,1'b1,3'b111,1'b0,8'hFF, 8'h22,1'b1,1'b0,1'b0};
        vecs[13] = '{1'b0,1'b0,1'b1,1'b1,3'b010,1'b1,8'hFF, 8'h22,1'b1,1'b0,1'b0};
        vecs[14] = '{1'b0,1'b1,1'b1,1'b1,3'b000,1'b0,8'h00, 8'h91,1'b0,1'b0,1'b0};
        vecs[15] = '{1'b0,1'b1,1'b0,1'b0,3'b001,1'b0,8'h00, 8'h23,1'b1,1'b0,1'b0};

        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0, 8'h00);
        #1;
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].enb, vecs[i].dir, vecs[i].s_in, vecs[i].modo, vecs[i].start, vecs[i].d);
            tick();
            chk($sformatf("vec%0d_q", i), Q, vecs[i].exp_q);
            chk($sformatf("vec%0d_sout", i), S_OUT, vecs[i].exp_sout);
            chk($sformatf("vec%0d_busy", i), BUSY, vecs[i].exp_busy);
            chk($sformatf("vec%0d_done", i), DONE, vecs[i].exp_done);
        end

        // Plain burst, LSB first.
        run_burst(1'b0, 1'b0, 8'hB1);
        // Same burst with a 3-cycle stall after the 4th shift and a START while busy.
        run_burst(1'b1, 1'b1, 8'hB1);

        // Reset mid-burst after the 4th shift.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 1'b1, 8'hB1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 1'b0, 8'h00);
            tick();
        end
        chk("pre_reset_q", Q, 8'h0B);
        chk("pre_reset_busy", BUSY, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 1'b0, 8'h00);
        tick();
        chk("midrst_q", Q, 8'h00);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_sout", S_OUT, 0);
        chk("midrst_done", DONE, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 1'b0, 8'h00);
            tick();
            chk("midrst_no_done", DONE, 0);
            chk("midrst_no_busy", BUSY, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_register_param.md
Name: shift_register_param

Overview:
- Parametrised successor to the team's 4-bit shift register.
- Generic WIDTH universal shift register with these operations:
  - logical shift
  - circular rotate
  - arithmetic shift
  - parallel load
  - hold
- Adds an autonomous burst mode: on START it loads D, then serialises all WIDTH bits on S_OUT under a BUSY/DONE handshake.
- Used as a parallel-to-serial front end and general data-path shifter.

Parameters:
- WIDTH, 8, register width in bits; legal range is WIDTH >= 2.
- RST_VAL, 0, value loaded into Q on reset; WIDTH bits wide.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- ENB  input  1  clock enable; 0 = freeze all state (Q, S_OUT, count, FSM).
- DIR  input  1  0 = shift toward MSB (left), 1 = shift toward LSB (right).
- S_IN  input  1  serial input bit.
- MODO  input  3  operation select (IDLE only).
- START  input  1  burst request.
- D  input  WIDTH  parallel data.
- Q  output  WIDTH  register contents (registered).
- S_OUT  output  1  last bit shifted out (registered).
- BUSY  output  1  burst in progress (registered).
- DONE  output  1  one-cycle burst-complete pulse (registered).

Behaviour:
- Reset (RST=1 at posedge, overrides ENB/START):
  - Q=RST_VAL, S_OUT=0, BUSY=0, DONE=0, FSM=IDLE, count=0.
  - Reset mid-burst aborts the burst; DONE is not asserted.
- DONE defaults to 0 every cycle unless set as described below, including cycles with ENB=0.
- FSM states: IDLE, SHIFT. Internal count has width $clog2(WIDTH+1).
- IDLE, ENB=0: everything holds.
- IDLE, ENB=1, START=1 (START has priority over MODO):
  - Q<=D, dir_l<=DIR, count<=WIDTH, BUSY<=1, state<=SHIFT.
  - S_OUT unchanged.
- IDLE, ENB=1, START=0, ops by MODO. Left = DIR=0, right = DIR=1:
  - 000 logical shift:
    - Left: Q<={Q[W-2:0],S_IN}, S_OUT<=Q[W-1].
    - Right: Q<={S_IN,Q[W-1:1]}, S_OUT<=Q[0].
  - 001 rotate:
    - Left: Q<={Q[W-2:0],Q[W-1]}, S_OUT<=Q[W-1].
    - Right: Q<={Q[0],Q[W-1:1]}, S_OUT<=Q[0].
  - 010 parallel load: Q<=D, S_OUT unchanged.
  - 011 hold.
  - 100 arithmetic shift, S_IN ignored:
    - Right: Q<={Q[W-1],Q[W-1:1]}, S_OUT<=Q[0].
    - Left: Q<={Q[W-2:0],1'b0}, S_OUT<=Q[W-1].
  - 101..111: hold (reserved).
- SHIFT, ENB=1:
  - Performs a logical shift in direction dir_l with S_IN fill and S_OUT as in mode 000.
  - count<=count-1.
  - On the shift where count==1: state<=IDLE, BUSY<=0, DONE<=1.
- SHIFT, ENB=0: stall; Q, S_OUT, count and BUSY all hold.
- During SHIFT, MODO, DIR, D and START are ignored; START while BUSY is dropped, not queued.
- Burst timing: START edge, then exactly WIDTH shift edges with ENB=1.
  - BUSY is high for WIDTH cycles plus any stall cycles.
  - S_OUT emits bits in order: LSB first if DIR=1, MSB first if DIR=0.
- A new START is accepted in the same cycle DONE is high (state is IDLE).
- All outputs come from flops; there are no combinational input-to-output paths.

Test Plan:
1. Reset: RST=1 with ENB=1, START=1, D=8'hFF → next cycle Q=8'h00, S_OUT=0, BUSY=0, DONE=0.
2. Rotate: load D=8'hA5 (MODO=010).
   - MODO=001, DIR=0 → Q=8'h4B, S_OUT=1.
   - Reload 8'hA5, then MODO=001, DIR=1 → Q=8'hD2, S_OUT=1.
3. Arithmetic vs logical right shift: load 8'h90.
   - MODO=100, DIR=1, S_IN=0 → Q=8'hC8, S_OUT=0.
   - Reload 8'h90, then MODO=000, DIR=1, S_IN=0 → Q=8'h48.
4. Burst: D=8'hB1, DIR=1, S_IN=0, START pulse.
   - S_OUT over the next 8 edges = 1,0,0,0,1,1,0,1.
   - BUSY high for 8 cycles; DONE high for exactly 1 cycle at BUSY fall; final Q=8'h00.
5. Stall and ignored START: repeat test 4 with ENB=0 for 3 cycles after the 4th shift, and START=1 pulsed while BUSY.
   - Identical S_OUT sequence; BUSY high for 11 cycles; only one DONE; no second burst starts.
6. Reset mid-burst: RST=1 after the 4th shift → next cycle Q=RST_VAL, BUSY=0; DONE stays 0 for the following 10 cycles.
